twiddle_mult_pipe: RTL and testbench



---
 rtl/fft_twiddle_pkg.sv | 10 +
 rtl/twiddle_mult_pipe_if.sv | 32 +++
 rtl/twiddle_mult_pipe_cmult_lane.sv | 110 +++++++++++
 rtl/twiddle_mult_pipe.sv | 70 +++++++
 tb/tb_twiddle_mult_pipe.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/fft_twiddle_pkg.sv
// Shared widths and latency for the FFT twiddle datapath.
// The pipeline latency is exported so neighbouring blocks can align to it.
package fft_twiddle_pkg;
   localparam int DEF_DATA_W    = 16;
   localparam int DEF_TW_W      = 8;
   localparam int DEF_FRAC_BITS = 7;
   localparam int DEF_PROD_W    = DEF_DATA_W + DEF_TW_W;
   localparam int DEF_SUM_W     = DEF_PROD_W + 1;
   localparam int LATENCY       = 3;
endpackage

// File: rtl/twiddle_mult_pipe_if.sv
// Beat bus for the twiddle multiplier: valid/ready in, valid/ready out,
// lane-packed sample and twiddle vectors, and the sticky saturation flag.
interface twiddle_mult_pipe_if
   import fft_twiddle_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int DATA_W = DEF_DATA_W,
   parameter int TW_W   = DEF_TW_W
);
   logic                    in_valid;
   logic                    in_ready;
   logic [LANES*DATA_W-1:0] in_re;
   logic [LANES*DATA_W-1:0] in_im;
   logic [LANES*TW_W-1:0]   tw_re;
   logic [LANES*TW_W-1:0]   tw_im;
   logic                    out_valid;
   logic                    out_ready;
   logic [LANES*DATA_W-1:0] out_re;
   logic [LANES*DATA_W-1:0] out_im;
   logic                    sat_flag;
   logic                    sat_clr;

   modport slave (
      input  in_valid, in_re, in_im, tw_re, tw_im, out_ready, sat_clr,
      output in_ready, out_valid, out_re, out_im, sat_flag
   );

   modport master (
      output in_valid, in_re, in_im, tw_re, tw_im, out_ready, sat_clr,
      input  in_ready, out_valid, out_re, out_im, sat_flag
   );
endinterface

// File: rtl/twiddle_mult_pipe_cmult_lane.sv
// One lane of the complex twiddle multiplier: S1 products, S2 sums,
// S3 round/shift/saturate. Optional macro TWIDDLE_ROUND_EN adds a
// half-LSB before the shift (round half up); without it the shift floors.
// A bypass lane feeds sample<<FRAC_BITS through the same registers, so the
// S3 shift returns the sample bit-exact and it stays cycle-aligned.
module cmult_lane
   import fft_twiddle_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int TW_W      = DEF_TW_W,
   parameter int FRAC_BITS = DEF_FRAC_BITS,
   parameter bit BYPASS    = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_adv,
   input  logic [2:0]        i_vld,   // stage-input valids for S1, S2, S3
   input  logic [DATA_W-1:0] i_re,
   input  logic [DATA_W-1:0] i_im,
   input  logic [TW_W-1:0]   i_twr,
   input  logic [TW_W-1:0]   i_twi,
   output logic [DATA_W-1:0] o_re,
   output logic [DATA_W-1:0] o_im,
   output logic              o_sat
);
   localparam int PROD_W = DATA_W + TW_W;
   localparam int SUM_W  = PROD_W + 1;

`ifdef TWIDDLE_ROUND_EN
   localparam logic signed [SUM_W:0] RND = (SUM_W+1)'(1) <<< (FRAC_BITS-1);
`else
   localparam logic signed [SUM_W:0] RND = '0;
`endif
   localparam logic signed [SUM_W:0] OMAX = (SUM_W+1)'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
   localparam logic signed [SUM_W:0] OMIN = (SUM_W+1)'(-(64'sd1 <<< (DATA_W-1)));

   // Returns {saturated, result} for one full-precision sum.
   function automatic logic [DATA_W:0] f_rsat(input logic [SUM_W-1:0] v);
      logic signed [SUM_W:0] t;
      t = $signed({v[SUM_W-1], v}) + RND;
      t = t >>> FRAC_BITS;
      if (t > OMAX)      return {1'b1, OMAX[DATA_W-1:0]};
      else if (t < OMIN) return {1'b1, OMIN[DATA_W-1:0]};
      return {1'b0, t[DATA_W-1:0]};
   endfunction

   logic signed [PROD_W-1:0] w_are, w_aim, w_btr, w_bti;
   logic signed [PROD_W-1:0] w_prr, w_pii, w_pri, w_pir;
   logic signed [PROD_W-1:0] r_prr, r_pii, r_pri, r_pir;
   logic [SUM_W-1:0]         r_re_full, r_im_full;
   logic [DATA_W:0]          w_q_re, w_q_im;
   logic [DATA_W-1:0]        r_ore, r_oim;

   assign w_are = {{TW_W{i_re[DATA_W-1]}}, i_re};
   assign w_aim = {{TW_W{i_im[DATA_W-1]}}, i_im};
   assign w_btr = {{DATA_W{i_twr[TW_W-1]}}, i_twr};
   assign w_bti = {{DATA_W{i_twi[TW_W-1]}}, i_twi};

   // Product selection: real multiply, or scaled pass-through for bypass.
   always_comb begin
      w_prr = w_are * w_btr;
      w_pii = w_aim * w_bti;
      w_pri = w_are * w_bti;
      w_pir = w_aim * w_btr;
      if (BYPASS) begin
         w_prr = w_are <<< FRAC_BITS;
         w_pii = '0;
         w_pri = '0;
         w_pir = w_aim <<< FRAC_BITS;
      end
   end

   // S1: product registers, loaded only for a valid beat on advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prr <= '0; r_pii <= '0; r_pri <= '0; r_pir <= '0;
      end else if (i_adv && i_vld[0]) begin
         r_prr <= w_prr; r_pii <= w_pii; r_pri <= w_pri; r_pir <= w_pir;
      end
   end

   // S2: full-precision complex sums, one guard bit above the products.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_re_full <= '0;
         r_im_full <= '0;
      end else if (i_adv && i_vld[1]) begin
         r_re_full <= {r_prr[PROD_W-1], r_prr} - {r_pii[PROD_W-1], r_pii};
         r_im_full <= {r_pri[PROD_W-1], r_pri} + {r_pir[PROD_W-1], r_pir};
      end
   end

   assign w_q_re = f_rsat(r_re_full);
   assign w_q_im = f_rsat(r_im_full);

   // S3: rounded, shifted, clamped output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ore <= '0;
         r_oim <= '0;
      end else if (i_adv && i_vld[2]) begin
         r_ore <= w_q_re[DATA_W-1:0];
         r_oim <= w_q_im[DATA_W-1:0];
      end
   end

   assign o_re  = r_ore;
   assign o_im  = r_oim;
   assign o_sat = !BYPASS && (w_q_re[DATA_W] || w_q_im[DATA_W]);
endmodule

// File: rtl/twiddle_mult_pipe.sv
// Multi-lane complex twiddle multiplier with valid/ready stall, bypass
// lanes and sticky saturation flag. Rounding mode is chosen by the
// TWIDDLE_ROUND_EN macro inside cmult_lane.
module twiddle_mult_pipe
   import fft_twiddle_pkg::*;
#(
   parameter int               LANES       = 4,
   parameter int               DATA_W      = DEF_DATA_W,
   parameter int               TW_W        = DEF_TW_W,
   parameter int               FRAC_BITS   = DEF_FRAC_BITS,
   parameter logic [LANES-1:0] BYPASS_MASK = LANES'(1)
) (
   input logic                clk,
   input logic                rst_n,
   twiddle_mult_pipe_if.slave bus
);
   logic                          w_adv;
   logic [LATENCY:1]              r_vld_pipe;
   logic                          r_sat;
   logic [LANES-1:0]              w_sat;
   logic [LANES-1:0][DATA_W-1:0]  w_ire, w_iim, w_ore, w_oim;
   logic [LANES-1:0][TW_W-1:0]    w_twr, w_twi;

   // Whole pipeline moves together whenever the output slot is free.
   assign w_adv        = bus.out_ready || !r_vld_pipe[LATENCY];
   assign bus.in_ready = w_adv;
   assign bus.out_valid = r_vld_pipe[LATENCY];
   assign bus.sat_flag = r_sat;

   assign w_ire = bus.in_re;
   assign w_iim = bus.in_im;
   assign w_twr = bus.tw_re;
   assign w_twi = bus.tw_im;
   assign bus.out_re = w_ore;
   assign bus.out_im = w_oim;

   // Per-stage valid shift chain; bubbles shift through as zeros.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_vld_pipe <= '0;
      else if (w_adv) r_vld_pipe <= {r_vld_pipe[LATENCY-1:1], bus.in_valid};
   end

   // Sticky saturation: set when a clamped beat enters S3; set beats clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                      r_sat <= 1'b0;
      else if (w_adv && r_vld_pipe[LATENCY-1] && |w_sat) r_sat <= 1'b1;
      else if (bus.sat_clr)                            r_sat <= 1'b0;
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      cmult_lane #(
         .DATA_W    (DATA_W),
         .TW_W      (TW_W),
         .FRAC_BITS (FRAC_BITS),
         .BYPASS    (BYPASS_MASK[k])
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .i_adv (w_adv),
         .i_vld ({r_vld_pipe[LATENCY-1:1], bus.in_valid}),
         .i_re  (w_ire[k]),
         .i_im  (w_iim[k]),
         .i_twr (w_twr[k]),
         .i_twi (w_twi[k]),
         .o_re  (w_ore[k]),
         .o_im  (w_oim[k]),
         .o_sat (w_sat[k])
      );
   end
endmodule

// File: tb/tb_twiddle_mult_pipe.sv
// Directed bench for twiddle_mult_pipe: latency, bypass, rounding,
// saturation/sticky flag, backpressure ordering, bubbles and async reset.
module tb_twiddle_mult_pipe;
   import fft_twiddle_pkg::*;
   localparam int LN = 4, DW = 16, TW = 8;
`ifdef TWIDDLE_ROUND_EN
   localparam int RND_POS = 2, RND_NEG = -1;
`else
   localparam int RND_POS = 1, RND_NEG = -2;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   twiddle_mult_pipe_if #(.LANES(LN), .DATA_W(DW), .TW_W(TW)) bus();

   twiddle_mult_pipe #(
      .LANES(LN), .DATA_W(DW), .TW_W(TW), .FRAC_BITS(7), .BYPASS_MASK(4'b0001)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int n_tot = 0, n_pass = 0, n_fail = 0;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      bus.in_re = '0; bus.in_im = '0; bus.tw_re = '0; bus.tw_im = '0;
   endtask

   task automatic set_lane(input int k, input int re, input int im, input int twr, input int twi);
      bus.in_re[k*DW +: DW] = re[DW-1:0];
      bus.in_im[k*DW +: DW] = im[DW-1:0];
      bus.tw_re[k*TW +: TW] = twr[TW-1:0];
      bus.tw_im[k*TW +: TW] = twi[TW-1:0];
   endtask

   function automatic logic signed [31:0] ore(input int k);
      return $signed(bus.out_re[k*DW +: DW]);
   endfunction

   function automatic logic signed [31:0] oim(input int k);
      return $signed(bus.out_im[k*DW +: DW]);
   endfunction

   int sent, rcv;
   logic stall, acc, xfer;
   logic signed [31:0] h0, h1;
   int vpat[8] = '{1, 0, 1, 0, 0, 0, 0, 0};

   initial begin
      bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.sat_clr = 1'b0;
      clr_in();
      #12;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_sat_flag", bus.sat_flag, 0);
      chk("rst_out_zero", |{bus.out_re, bus.out_im}, 0);
      rst_n = 1'b1;
      tick();

      // Basic beat: latency, bypass lane, real and imaginary twiddles
      set_lane(0, 1234, -5, 99, -99);
      set_lane(1, 1000, 0, 64, 0);
      set_lane(3, 100, 50, 0, 64);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("lat_e1", bus.out_valid, 0);
      tick();
      chk("lat_e2", bus.out_valid, 0);
      tick();
      chk("lat_e3", bus.out_valid, 1);
      chk("byp_re", ore(0), 1234);
      chk("byp_im", oim(0), -5);
      chk("l1_re", ore(1), 500);
      chk("l1_im", oim(1), 0);
      chk("l3_re", ore(3), -25);
      chk("l3_im", oim(3), 50);
      tick();
      chk("lat_e4", bus.out_valid, 0);

      // Rounding: +3 then -3 times 0.5
      clr_in();
      set_lane(1, 3, 0, 64, 0);
      bus.in_valid = 1'b1;
      tick();
      set_lane(1, -3, 0, 64, 0);
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("rnd_pos", ore(1), RND_POS);
      tick();
      chk("rnd_neg", ore(1), RND_NEG);
      tick();

      // Saturation and sticky flag
      clr_in();
      set_lane(2, 32767, 32767, 127, 127);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("sat_pre", bus.sat_flag, 0);
      tick();
      chk("sat_re", ore(2), 0);
      chk("sat_im", oim(2), 32767);
      chk("sat_set", bus.sat_flag, 1);
      tick();
      chk("sat_hold", bus.sat_flag, 1);
      bus.sat_clr = 1'b1;
      tick();
      bus.sat_clr = 1'b0;
      chk("sat_clr", bus.sat_flag, 0);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      bus.sat_clr = 1'b1;
      tick();
      bus.sat_clr = 1'b0;
      chk("sat_set_wins", bus.sat_flag, 1);
      bus.sat_clr = 1'b1;
      tick();
      bus.sat_clr = 1'b0;

      // Backpressure: 10 beats, out_ready pattern 1,0,0,1
      sent = 0; rcv = 0;
      for (int c = 0; c < 80 && rcv < 10; c++) begin
         bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
         bus.in_valid = (sent < 10);
         clr_in();
         set_lane(0, 100 + sent, 0, 0, 0);
         set_lane(1, sent * 256, 0, 64, 0);
         #1;
         chk("bp_in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
         acc = bus.in_valid && bus.in_ready;
         xfer = bus.out_valid && bus.out_ready;
         stall = bus.out_valid && !bus.out_ready;
         h0 = ore(0); h1 = ore(1);
         if (xfer) begin
            chk("bp_byp_order", ore(0), 100 + rcv);
            chk("bp_l1_order", ore(1), rcv * 128);
            rcv++;
         end
         if (acc) sent++;
         tick();
         if (stall) begin
            chk("bp_hold_valid", bus.out_valid, 1);
            chk("bp_hold_l0", ore(0), h0);
            chk("bp_hold_l1", ore(1), h1);
         end
      end
      chk("bp_sent", sent, 10);
      chk("bp_rcv", rcv, 10);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick();

      // Bubbles: valid pattern reproduced three edges later
      for (int t = 0; t < 8; t++) begin
         bus.in_valid = vpat[t][0];
         tick();
         if (t >= 2) chk("bubble", bus.out_valid, vpat[t-2]);
      end
      bus.in_valid = 1'b0;

      // Async reset mid-stream
      clr_in();
      set_lane(1, 1000, 0, 64, 0);
      set_lane(2, 32767, 32767, 127, 127);
      bus.in_valid = 1'b1;
      tick(); tick(); tick();
      chk("pre_rst_valid", bus.out_valid, 1);
      chk("pre_rst_sat", bus.sat_flag, 1);
      #2;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("arst_valid", bus.out_valid, 0);
      chk("arst_sat", bus.sat_flag, 0);
      chk("arst_re", |bus.out_re, 0);
      chk("arst_im", |bus.out_im, 0);
      #2;
      rst_n = 1'b1;
      for (int t = 0; t < 3; t++) begin
         tick();
         chk("post_rst_empty", bus.out_valid, 0);
      end
      clr_in();
      set_lane(1, 2000, 0, 64, 0);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("post_rst_e2", bus.out_valid, 0);
      tick();
      chk("post_rst_valid", bus.out_valid, 1);
      chk("post_rst_l1", ore(1), 1000);
      chk("post_rst_l2", oim(2), 0);
      chk("post_rst_sat", bus.sat_flag, 0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
